digit_entry_controller: RTL and testbench

- Input-side counterpart to the seven-segment display path: turns raw board pushbuttons and switches into the eight BCD digit values and per-digit enable mask that the display control consumes.
- Debounces and edge-detects the four active-low KEY inputs.
- Each clean press performs one edit operation on an internal 8-digit register bank.
- The bank drives the display block directly, giving the board persistent, user-editable digits instead of live switch mirroring.

---
 rtl/digit_entry_pkg.sv | 20 ++
 rtl/key_debouncer.sv | 53 +++++
 rtl/digit_entry_controller.sv | 96 +++++++++
 tb/tb_digit_entry_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the pushbutton digit-entry path.
package digit_entry_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_WRITE,
    OP_SHIFT,
    OP_BLANK,
    OP_CLEAR
  } op_t;

  localparam int unsigned KEY_WRITE  = 0;
  localparam int unsigned KEY_SHIFT  = 1;
  localparam int unsigned KEY_BLANK  = 2;
  localparam int unsigned KEY_CLEAR  = 3;

  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam int unsigned NUM_DIGITS = 8;

endpackage

// File: rtl/key_debouncer.sv
// One active-low pushbutton: 2-flop sync, counter debounce, one-cycle press pulse.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic pressed_pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          prev_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Pulse is registered off the previous stable level so it lands one cycle after the rise.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= ~raw_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      pulse_q  <= stable_q & ~prev_q;
      cnt_q    <= cnt_d;
    end
  end

  assign pressed_pulse = pulse_q;

endmodule

// File: rtl/digit_entry_controller.sv
// Debounced pushbutton editor for an 8-digit BCD bank feeding the display block.
module digit_entry_controller
  import digit_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned NUM_KEYS        = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [3:0]                key_n,
  input  logic [3:0]                sw_data,
  input  logic [2:0]                sw_sel,
  output logic [4*NUM_DIGITS-1:0]   bcd,
  output logic [NUM_DIGITS-1:0]     turn_on,
  output logic                      error,
  output logic [3:0]                key_pressed
);

  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   turn_on_q, turn_on_d;
  logic                    error_q, error_d;
  logic                    data_ok;
  op_t                     op;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clock        (clock),
      .reset        (reset),
      .raw_n        (key_n[k]),
      .pressed_pulse(key_pressed[k])
    );
  end

  // Simultaneous presses: CLEAR > BLANK > WRITE > SHIFT.
  always_comb begin
    op = OP_NONE;
    if (key_pressed[KEY_CLEAR])      op = OP_CLEAR;
    else if (key_pressed[KEY_BLANK]) op = OP_BLANK;
    else if (key_pressed[KEY_WRITE]) op = OP_WRITE;
    else if (key_pressed[KEY_SHIFT]) op = OP_SHIFT;
  end

  assign data_ok = (sw_data <= BCD_MAX);

  always_comb begin
    bcd_d     = bcd_q;
    turn_on_d = turn_on_q;
    error_d   = error_q;
    unique case (op)
      OP_WRITE: begin
        if (data_ok) begin
          bcd_d[{sw_sel, 2'b00} +: 4] = sw_data;
          turn_on_d[sw_sel]           = 1'b1;
          error_d                     = 1'b0;
        end else begin
          error_d = 1'b1;
        end
      end
      OP_SHIFT: begin
        if (data_ok) begin
          bcd_d     = {bcd_q[4*NUM_DIGITS-5:0], sw_data};
          turn_on_d = {turn_on_q[NUM_DIGITS-2:0], 1'b1};
          error_d   = 1'b0;
        end else begin
          error_d = 1'b1;
        end
      end
      OP_BLANK: turn_on_d[sw_sel] = 1'b0;
      OP_CLEAR: begin
        bcd_d     = '0;
        turn_on_d = '0;
        error_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bcd_q     <= '0;
      turn_on_q <= '0;
      error_q   <= 1'b0;
    end else begin
      bcd_q     <= bcd_d;
      turn_on_q <= turn_on_d;
      error_q   <= error_d;
    end
  end

  assign bcd     = bcd_q;
  assign turn_on = turn_on_q;
  assign error   = error_q;

endmodule

// File: tb/tb_digit_entry_controller.sv
// Directed bench for digit_entry_controller with a short debounce window.
module tb_digit_entry_controller;

  localparam int unsigned DC = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  key_n = 4'hF;
  logic [3:0]  sw_data = 4'h0;
  logic [2:0]  sw_sel = 3'd0;
  logic [31:0] bcd;
  logic [7:0]  turn_on;
  logic        error;
  logic [3:0]  key_pressed;

  int n_cmp = 0;
  int n_err = 0;

  digit_entry_controller #(
    .DEBOUNCE_CYCLES(DC),
    .NUM_KEYS(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_n      (key_n),
    .sw_data    (sw_data),
    .sw_sel     (sw_sel),
    .bcd        (bcd),
    .turn_on    (turn_on),
    .error      (error),
    .key_pressed(key_pressed)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  // Hold keys for 10 cycles, release for 12, tallying pulse cycles and pulsed keys.
  task automatic press(input logic [3:0] mask, output int pulses, output logic [3:0] seen);
    pulses = 0;
    seen   = '0;
    key_n  = ~mask;
    repeat (10) begin
      tick();
      if (key_pressed != 4'h0) pulses++;
      seen |= key_pressed;
    end
    key_n = 4'hF;
    repeat (12) begin
      tick();
      if (key_pressed != 4'h0) pulses++;
      seen |= key_pressed;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({bcd, turn_on, error, key_pressed} !== 45'h0) begin
      n_err++;
      $display("FAIL reset_state: got bcd=%h on=%h err=%b kp=%b, want all zero", bcd, turn_on, error, key_pressed);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_latency();
    logic [3:0]  exp_kp;
    logic [31:0] exp_bcd;
    logic [7:0]  exp_on;
    sw_sel  = 3'd3;
    sw_data = 4'd7;
    key_n   = 4'b1110;
    for (int c = 0; c < 10; c++) begin
      tick();
      exp_kp  = (c == 2 + DC) ? 4'b0001 : 4'b0000;
      exp_bcd = (c >= 3 + DC) ? 32'h0000_7000 : 32'h0;
      exp_on  = (c >= 3 + DC) ? 8'h08 : 8'h00;
      n_cmp++;
      if (key_pressed !== exp_kp || bcd !== exp_bcd || turn_on !== exp_on) begin
        n_err++;
        $display("FAIL write_latency c=%0d: got kp=%b bcd=%h on=%h, want kp=%b bcd=%h on=%h",
                 c, key_pressed, bcd, turn_on, exp_kp, exp_bcd, exp_on);
      end
    end
    key_n = 4'hF;
    repeat (12) tick();
    n_cmp++;
    if (bcd !== 32'h0000_7000 || error !== 1'b0) begin
      n_err++;
      $display("FAIL write_hold_once: got bcd=%h err=%b, want 00007000 0", bcd, error);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    logic [3:0] seen;
    pulses  = 0;
    sw_data = 4'd2;
    key_n   = 4'b1110;
    repeat (3) tick();
    key_n = 4'hF;
    repeat (12) begin
      tick();
      if (key_pressed != 4'h0) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || bcd !== 32'h0000_7000) begin
      n_err++;
      $display("FAIL glitch_ignored: got pulses=%0d bcd=%h, want 0 00007000", pulses, bcd);
    end
    pulses = 0;
    seen   = '0;
    key_n  = 4'b1110;
    repeat (6) begin
      tick();
      if (key_pressed != 4'h0) pulses++;
      seen |= key_pressed;
    end
    key_n = 4'hF;
    repeat (12) begin
      tick();
      if (key_pressed != 4'h0) pulses++;
      seen |= key_pressed;
    end
    n_cmp++;
    if (pulses != 1 || seen !== 4'b0001 || bcd !== 32'h0000_2000) begin
      n_err++;
      $display("FAIL short_press: got pulses=%0d kp=%b bcd=%h, want 1 0001 00002000", pulses, seen, bcd);
    end
  endtask

  task automatic test_shift();
    int pulses;
    logic [3:0] seen;
    for (int d = 1; d <= 9; d++) begin
      sw_data = 4'(d);
      press(4'b0010, pulses, seen);
      if (d == 1) begin
        n_cmp++;
        if (bcd !== 32'h0002_0001 || turn_on !== 8'h11 || pulses != 1) begin
          n_err++;
          $display("FAIL shift_first: got bcd=%h on=%h pulses=%0d, want 00020001 11 1", bcd, turn_on, pulses);
        end
      end
    end
    n_cmp++;
    if (bcd !== 32'h2345_6789 || turn_on !== 8'hFF || error !== 1'b0) begin
      n_err++;
      $display("FAIL shift_nine: got bcd=%h on=%h err=%b, want 23456789 ff 0", bcd, turn_on, error);
    end
  endtask

  task automatic test_error_blank();
    int pulses;
    logic [3:0] seen;
    sw_sel  = 3'd0;
    sw_data = 4'hC;
    press(4'b0001, pulses, seen);
    n_cmp++;
    if (error !== 1'b1 || bcd !== 32'h2345_6789 || turn_on !== 8'hFF) begin
      n_err++;
      $display("FAIL bad_write: got err=%b bcd=%h on=%h, want 1 23456789 ff", error, bcd, turn_on);
    end
    press(4'b0100, pulses, seen);
    n_cmp++;
    if (error !== 1'b1 || turn_on !== 8'hFE || bcd !== 32'h2345_6789) begin
      n_err++;
      $display("FAIL blank: got err=%b on=%h bcd=%h, want 1 fe 23456789", error, turn_on, bcd);
    end
    sw_data = 4'd5;
    press(4'b0001, pulses, seen);
    n_cmp++;
    if (error !== 1'b0 || turn_on !== 8'hFF || bcd !== 32'h2345_6785) begin
      n_err++;
      $display("FAIL good_write: got err=%b on=%h bcd=%h, want 0 ff 23456785", error, turn_on, bcd);
    end
    sw_data = 4'hA;
    press(4'b0010, pulses, seen);
    n_cmp++;
    if (error !== 1'b1 || turn_on !== 8'hFF || bcd !== 32'h2345_6785) begin
      n_err++;
      $display("FAIL bad_shift: got err=%b on=%h bcd=%h, want 1 ff 23456785", error, turn_on, bcd);
    end
  endtask

  task automatic test_priority();
    int pulses;
    logic [3:0] seen;
    sw_sel  = 3'd1;
    sw_data = 4'd3;
    press(4'b1001, pulses, seen);
    n_cmp++;
    if (seen !== 4'b1001 || pulses != 1 || bcd !== 32'h0 || turn_on !== 8'h00 || error !== 1'b0) begin
      n_err++;
      $display("FAIL clear_beats_write: got kp=%b pulses=%0d bcd=%h on=%h err=%b, want 1001 1 0 0 0",
               seen, pulses, bcd, turn_on, error);
    end
    press(4'b0001, pulses, seen);
    sw_data = 4'd9;
    press(4'b0101, pulses, seen);
    n_cmp++;
    if (seen !== 4'b0101 || bcd !== 32'h0000_0030 || turn_on !== 8'h00) begin
      n_err++;
      $display("FAIL blank_beats_write: got kp=%b bcd=%h on=%h, want 0101 00000030 00", seen, bcd, turn_on);
    end
    sw_sel  = 3'd2;
    sw_data = 4'd4;
    press(4'b0011, pulses, seen);
    n_cmp++;
    if (seen !== 4'b0011 || bcd !== 32'h0000_0430 || turn_on !== 8'h04) begin
      n_err++;
      $display("FAIL write_beats_shift: got kp=%b bcd=%h on=%h, want 0011 00000430 04", seen, bcd, turn_on);
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [3:0]  exp_kp;
    logic [31:0] exp_bcd;
    sw_sel  = 3'd5;
    sw_data = 4'd1;
    key_n   = 4'b1110;
    repeat (4) tick();
    reset = 1'b1;
    repeat (3) begin
      tick();
      n_cmp++;
      if ({bcd, turn_on, error, key_pressed} !== 45'h0) begin
        n_err++;
        $display("FAIL reset_mid: got bcd=%h on=%h err=%b kp=%b, want all zero", bcd, turn_on, error, key_pressed);
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 9; c++) begin
      tick();
      exp_kp  = (c == 2 + DC) ? 4'b0001 : 4'b0000;
      exp_bcd = (c >= 3 + DC) ? 32'h0010_0000 : 32'h0;
      n_cmp++;
      if (key_pressed !== exp_kp || bcd !== exp_bcd) begin
        n_err++;
        $display("FAIL post_reset_press c=%0d: got kp=%b bcd=%h, want kp=%b bcd=%h",
                 c, key_pressed, bcd, exp_kp, exp_bcd);
      end
    end
    n_cmp++;
    if (turn_on !== 8'h20) begin
      n_err++;
      $display("FAIL post_reset_on: got %h, want 20", turn_on);
    end
    key_n = 4'hF;
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_glitch();
    test_shift();
    test_error_blank();
    test_priority();
    test_reset_mid_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
